// File: rtl/apb_spi_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_xfer_ctrl_if
// Brief    : APB bus bundle between the transfer controller and the SPI wrapper
// Revision : 1.0
// ============================================================================
interface apb_spi_xfer_ctrl_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [7:0]  pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_xfer_ctrl
// Brief    : 2-client round-robin APB master sequencing TX write, status poll
//            and RX read through the SPI wrapper
// Revision : 1.0
// ============================================================================
module apb_spi_xfer_ctrl #(
  parameter logic [7:0] STATUS_ADDR = 8'h04,
  parameter logic [7:0] RXDATA_ADDR = 8'h08,
  parameter logic [7:0] TXDATA_ADDR = 8'h0C,
  parameter int         RXV_BIT     = 0,
  parameter int         POLL_MAX    = 16
) (
  input  wire logic            pclk_i,
  input  wire logic            presetn_i,
  input  wire logic            req0_i,
  input  wire logic [7:0]      tx0_i,
  output logic                 done0_o,
  output logic                 err0_o,
  output logic [7:0]           rx0_o,
  input  wire logic            req1_i,
  input  wire logic [7:0]      tx1_i,
  output logic                 done1_o,
  output logic                 err1_o,
  output logic [7:0]           rx1_o,
  output logic                 busy_o,
  apb_spi_xfer_ctrl_if.master  apb
);

  localparam logic [7:0] c_poll_max = 8'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WR_SETUP    = 3'd1,
    S_WR_ACCESS   = 3'd2,
    S_POLL_SETUP  = 3'd3,
    S_POLL_ACCESS = 3'd4,
    S_RD_SETUP    = 3'd5,
    S_RD_ACCESS   = 3'd6,
    S_DONE        = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic       id_q, id_d;
  logic       last_q, last_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [7:0] rx0_q, rx0_d;
  logic [7:0] rx1_q, rx1_d;
  logic       w_finish;
  logic [7:0] w_rx_res;

  // last_q resets to client 1 so that client 0 wins the first tie
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q <= S_IDLE;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      tx_q    <= 8'h00;
      cnt_q   <= 8'h00;
      err_q   <= 1'b0;
      rx0_q   <= 8'h00;
      rx1_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rx0_q   <= rx0_d;
      rx1_q   <= rx1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    last_d      = last_q;
    tx_d        = tx_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rx0_d       = rx0_q;
    rx1_d       = rx1_q;
    w_finish    = 1'b0;
    w_rx_res    = 8'h00;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = 8'h00;
    apb.pwdata  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          id_d    = (req0_i && req1_i) ? ~last_q : req1_i;
          tx_d    = id_d ? tx1_i : tx0_i;
          err_d   = 1'b0;
          state_d = S_WR_SETUP;
        end
      end
      S_WR_SETUP, S_WR_ACCESS: begin
        apb.psel    = 1'b1;
        apb.penable = (state_q == S_WR_ACCESS);
        apb.pwrite  = 1'b1;
        apb.paddr   = TXDATA_ADDR;
        apb.pwdata  = tx_q;
        if (state_q == S_WR_SETUP) begin
          state_d = S_WR_ACCESS;
        end else if (apb.pready) begin
          if (apb.pslverr) begin
            err_d    = 1'b1;
            w_finish = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d   = 8'h00;
            state_d = S_POLL_SETUP;
          end
        end
      end
      S_POLL_SETUP, S_POLL_ACCESS: begin
        apb.psel    = 1'b1;
        apb.penable = (state_q == S_POLL_ACCESS);
        apb.paddr   = STATUS_ADDR;
        if (state_q == S_POLL_SETUP) begin
          state_d = S_POLL_ACCESS;
        end else if (apb.pready) begin
          cnt_d = cnt_q + 8'd1;
          if (apb.pslverr || (!apb.prdata[RXV_BIT] && (cnt_d == c_poll_max))) begin
            err_d    = 1'b1;
            w_finish = 1'b1;
            state_d  = S_DONE;
          end else if (apb.prdata[RXV_BIT]) begin
            state_d = S_RD_SETUP;
          end else begin
            state_d = S_POLL_SETUP;
          end
        end
      end
      S_RD_SETUP, S_RD_ACCESS: begin
        apb.psel    = 1'b1;
        apb.penable = (state_q == S_RD_ACCESS);
        apb.paddr   = RXDATA_ADDR;
        if (state_q == S_RD_SETUP) begin
          state_d = S_RD_ACCESS;
        end else if (apb.pready) begin
          w_finish = 1'b1;
          state_d  = S_DONE;
          if (apb.pslverr) begin
            err_d = 1'b1;
          end else begin
            w_rx_res = apb.prdata[7:0];
          end
        end
      end
      S_DONE: begin
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Result lands in the granted client's hold register as DONE is entered
    if (w_finish) begin
      if (id_q) rx1_d = w_rx_res;
      else      rx0_d = w_rx_res;
    end
  end

  assign done0_o = (state_q == S_DONE) && !id_q;
  assign done1_o = (state_q == S_DONE) &&  id_q;
  assign err0_o  = done0_o && err_q;
  assign err1_o  = done1_o && err_q;
  assign rx0_o   = rx0_q;
  assign rx1_o   = rx1_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule
`default_nettype wire
